// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the instruction-fetch requester
//   (read-only) and the memory-stage data requester (read/write). Only one
//   transaction is outstanding at a time. The data side wins ties unless
//   fetch has waited through STARVE_LIMIT back-to-back data grants.
//
// Ports
//   clk, rst_n                 core clock, asynchronous active-low reset
//   if_req_valid/ready, if_addr          fetch request handshake
//   if_rsp_valid, if_rdata               fetch response (one-cycle pulse)
//   dm_req_valid/ready, dm_addr, dm_we,
//   dm_be, dm_wdata                      data request handshake
//   dm_rsp_valid, dm_rdata               data response / write completion
//   mem_req_valid/ready, mem_addr, mem_we,
//   mem_be, mem_wdata                    registered request to memory
//   mem_rsp_valid, mem_rdata             memory response / write ack
//   busy                                 a transaction is in progress
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rdata,

  input  logic                dm_req_valid,
  output logic                dm_req_ready,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_rsp_valid,
  output logic [DATA_W-1:0]   dm_rdata,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]        state_reg;
  logic              owner_reg;
  logic [3:0]        starve_cnt_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              mem_we_reg;
  logic [BE_W-1:0]   mem_be_reg;
  logic [DATA_W-1:0] mem_wdata_reg;

  logic idle;
  logic starved;
  logic grant_dm;
  logic grant_if;

  // Arbitration is purely combinational in IDLE. Readies are also gated by
  // rst_n because the asynchronous reset holds the FSM in IDLE, where an
  // ungated arbiter would otherwise raise a ready during reset.
  assign idle     = (state_reg == ST_IDLE) && rst_n;
  assign starved  = if_req_valid && (starve_cnt_reg == LIMIT);
  assign grant_dm = idle && dm_req_valid && !starved;
  assign grant_if = idle && if_req_valid && !grant_dm;

  assign if_req_ready = grant_if;
  assign dm_req_ready = grant_dm;

  assign mem_req_valid = (state_reg == ST_ISSUE);
  assign mem_addr      = mem_addr_reg;
  assign mem_we        = mem_we_reg;
  assign mem_be        = mem_be_reg;
  assign mem_wdata     = mem_wdata_reg;

  // Responses are only honoured in WAIT, so a stray pulse in IDLE/ISSUE or
  // one coincident with the issue handshake never reaches a requester.
  assign if_rsp_valid = (state_reg == ST_WAIT) && mem_rsp_valid && (owner_reg == OWNER_IF);
  assign dm_rsp_valid = (state_reg == ST_WAIT) && mem_rsp_valid && (owner_reg == OWNER_DM);
  assign if_rdata     = mem_rdata;
  assign dm_rdata     = mem_rdata;

  assign busy = (state_reg != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= OWNER_IF;
      starve_cnt_reg <= '0;
      mem_addr_reg   <= '0;
      mem_we_reg     <= 1'b0;
      mem_be_reg     <= '0;
      mem_wdata_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_dm) begin
            state_reg     <= ST_ISSUE;
            owner_reg     <= OWNER_DM;
            mem_addr_reg  <= dm_addr;
            mem_we_reg    <= dm_we;
            mem_be_reg    <= dm_be;
            mem_wdata_reg <= dm_wdata;
            // Count only grants that made fetch wait; saturate at the limit.
            if (if_req_valid) begin
              if (starve_cnt_reg < LIMIT) begin
                starve_cnt_reg <= starve_cnt_reg + 4'd1;
              end
            end else begin
              starve_cnt_reg <= '0;
            end
          end else if (grant_if) begin
            state_reg      <= ST_ISSUE;
            owner_reg      <= OWNER_IF;
            mem_addr_reg   <= if_addr;
            mem_we_reg     <= 1'b0;
            mem_be_reg     <= '1;
            mem_wdata_reg  <= '0;
            starve_cnt_reg <= '0;
          end
        end
        ST_ISSUE: begin
          if (mem_req_ready) begin
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
